cattrap_game_ctrl: RTL and testbench

- Game sequencer for the 8x8 CatTrap board.
- Owns the board state: 64 blocked flags, cat position and the player cursor.
- Takes debounced button levels, edge-detects them and runs the START/PLAY/LOSE/WIN flow: player places a block, then the cat steps.
- The VGA pixel renderer reads it through a combinational cell-query port, replacing the hard-coded per-block colours.

---
 rtl/cattrap_game_ctrl.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_cattrap_game_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cattrap_game_ctrl.sv
// cattrap_game_ctrl: game sequencer for the 8x8 CatTrap board. It owns the
// blocked map, the cat position and the player cursor, and runs the
// START -> PLAY -> LOSE/WIN flow from debounced button levels.
// Button events are registered, so an event acts one edge after its level is first sampled.
// Latency: a confirm placement resolves the cat move 7 edges after the BtnC level is first sampled.
// Backpressure: none. Button events that arrive while a turn is being resolved are dropped.
// Ports:
//   clk, rst_n                 clock and synchronous active-low reset
//   BtnC/BtnU/BtnD/BtnL/BtnR   debounced button levels (confirm, up, down, left, right)
//   rd_row, rd_col             renderer cell query
//   rd_cell, rd_cursor         combinational query result (0 free, 1 blocked, 2 cat) and cursor hit
//   game_state                 0 START, 1 PLAY, 2 LOSE, 3 WIN
//   cat_row/cat_col, cur_row/cur_col, move_count   board status
// Optional feature macro: CATTRAP_PREBLOCK_EN. When it is defined, random pre-blocking runs
// on START -> PLAY.
module cattrap_game_ctrl #(
  parameter int unsigned CAT_START_ROW = 3,
  parameter int unsigned CAT_START_COL = 3,
`ifdef CATTRAP_PREBLOCK_EN
  parameter int unsigned NUM_PREBLOCK  = 6,
`endif
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       BtnC,
  input  logic       BtnU,
  input  logic       BtnD,
  input  logic       BtnL,
  input  logic       BtnR,
  input  logic [2:0] rd_row,
  input  logic [2:0] rd_col,
  output logic [1:0] rd_cell,
  output logic       rd_cursor,
  output logic [1:0] game_state,
  output logic [2:0] cat_row,
  output logic [2:0] cat_col,
  output logic [2:0] cur_row,
  output logic [2:0] cur_col,
  output logic [6:0] move_count
);

  typedef enum logic [2:0] {
    S_START     = 3'd0,
    S_PLAY_WAIT = 3'd1,
    S_PLACE     = 3'd2,
    S_CAT_EVAL  = 3'd3,
    S_CAT_MOVE  = 3'd4,
    S_LOSE      = 3'd5,
    S_WIN       = 3'd6,
    S_PREBLOCK  = 3'd7
  } state_e;

  localparam logic [2:0] CAT_R0 = 3'(CAT_START_ROW);
  localparam logic [2:0] CAT_C0 = 3'(CAT_START_COL);

  state_e      state_q, state_d;
  logic [63:0] blocked_q, blocked_d;
  logic [2:0]  cat_row_q, cat_row_d, cat_col_q, cat_col_d;
  logic [2:0]  cur_row_q, cur_row_d, cur_col_q, cur_col_d;
  logic [6:0]  move_count_q, move_count_d;
  logic [15:0] lfsr_q;
  logic [4:0]  btn_prev_q, btn_evt_q;   // {C, U, D, L, R}
  logic [1:0]  k_q, k_d;
  logic        best_vld_q, best_vld_d;
  logic [2:0]  best_row_q, best_row_d, best_col_q, best_col_d;
  logic [2:0]  best_dist_q, best_dist_d;
`ifdef CATTRAP_PREBLOCK_EN
  logic [7:0]  pb_cnt_q, pb_cnt_d, pb_cyc_q, pb_cyc_d;
`endif

  logic [4:0]  btn_lvl;
  logic        evt_c, evt_u, evt_d, evt_l, evt_r;
  logic [5:0]  cat_idx, cur_idx;
  logic [2:0]  nb_row, nb_col, nb_dist;
  logic        nb_better;

  assign btn_lvl = {BtnC, BtnU, BtnD, BtnL, BtnR};
  assign {evt_c, evt_u, evt_d, evt_l, evt_r} = btn_evt_q;
  assign cat_idx = {cat_row_q, cat_col_q};
  assign cur_idx = {cur_row_q, cur_col_q};

  function automatic logic [2:0] edge_dist(input logic [2:0] r, input logic [2:0] c);
    logic [2:0] m;
    m = r;
    if (c < m)           m = c;
    if ((3'd7 - r) < m)  m = 3'd7 - r;
    if ((3'd7 - c) < m)  m = 3'd7 - c;
    return m;
  endfunction

  // Neighbour examined in evaluation step k: Up, Left, Down, Right.
  // The cat is interior whenever this is used, so no bounds handling is needed.
  always_comb begin
    nb_row = cat_row_q;
    nb_col = cat_col_q;
    case (k_q)
      2'd0:    nb_row = cat_row_q - 3'd1;
      2'd1:    nb_col = cat_col_q - 3'd1;
      2'd2:    nb_row = cat_row_q + 3'd1;
      default: nb_col = cat_col_q + 3'd1;
    endcase
  end

  assign nb_dist   = edge_dist(nb_row, nb_col);
  // Strictly-smaller compare keeps the earliest neighbour on ties.
  assign nb_better = !blocked_q[{nb_row, nb_col}] && (!best_vld_q || (nb_dist < best_dist_q));

  always_comb begin
    state_d      = state_q;
    blocked_d    = blocked_q;
    cat_row_d    = cat_row_q;
    cat_col_d    = cat_col_q;
    cur_row_d    = cur_row_q;
    cur_col_d    = cur_col_q;
    move_count_d = move_count_q;
    k_d          = k_q;
    best_vld_d   = best_vld_q;
    best_row_d   = best_row_q;
    best_col_d   = best_col_q;
    best_dist_d  = best_dist_q;
`ifdef CATTRAP_PREBLOCK_EN
    pb_cnt_d     = pb_cnt_q;
    pb_cyc_d     = pb_cyc_q;
`endif

    case (state_q)
      S_START: begin
        if (evt_c) begin
`ifdef CATTRAP_PREBLOCK_EN
          state_d = S_PREBLOCK;
`else
          state_d = S_PLAY_WAIT;
`endif
        end
      end

`ifdef CATTRAP_PREBLOCK_EN
      S_PREBLOCK: begin
        pb_cyc_d = pb_cyc_q + 8'd1;
        if (!blocked_q[lfsr_q[5:0]] && (lfsr_q[5:0] != cat_idx)) begin
          blocked_d[lfsr_q[5:0]] = 1'b1;
          pb_cnt_d = pb_cnt_q + 8'd1;
        end
        if ((pb_cnt_d == 8'(NUM_PREBLOCK)) || (pb_cyc_q == 8'(4 * NUM_PREBLOCK - 1))) begin
          state_d = S_PLAY_WAIT;
        end
      end
`endif

      S_PLAY_WAIT: begin
        // Confirm outranks any direction event in the same cycle.
        if (evt_c) begin
          if (!blocked_q[cur_idx] && (cur_idx != cat_idx)) begin
            state_d = S_PLACE;
          end
        end else if (evt_u) begin
          if (cur_row_q != 3'd0) cur_row_d = cur_row_q - 3'd1;
        end else if (evt_d) begin
          if (cur_row_q != 3'd7) cur_row_d = cur_row_q + 3'd1;
        end else if (evt_l) begin
          if (cur_col_q != 3'd0) cur_col_d = cur_col_q - 3'd1;
        end else if (evt_r) begin
          if (cur_col_q != 3'd7) cur_col_d = cur_col_q + 3'd1;
        end
      end

      S_PLACE: begin
        blocked_d[cur_idx] = 1'b1;
        if (move_count_q != 7'd127) move_count_d = move_count_q + 7'd1;
        k_d        = 2'd0;
        best_vld_d = 1'b0;
        state_d    = S_CAT_EVAL;
      end

      S_CAT_EVAL: begin
        k_d = k_q + 2'd1;
        if (nb_better) begin
          best_vld_d  = 1'b1;
          best_row_d  = nb_row;
          best_col_d  = nb_col;
          best_dist_d = nb_dist;
        end
        if (k_q == 2'd3) begin
          state_d = (best_vld_q || nb_better) ? S_CAT_MOVE : S_WIN;
        end
      end

      S_CAT_MOVE: begin
        cat_row_d = best_row_q;
        cat_col_d = best_col_q;
        if ((best_row_q == 3'd0) || (best_row_q == 3'd7) ||
            (best_col_q == 3'd0) || (best_col_q == 3'd7)) begin
          state_d = S_LOSE;
        end else begin
          state_d = S_PLAY_WAIT;
        end
      end

      S_LOSE, S_WIN: begin
        if (evt_c) state_d = S_START;
      end

      default: state_d = S_START;
    endcase

    // Clearing on entry as well as while resident means the board reads
    // empty on the very edge a finished game returns to START.
    if (state_d == S_START) begin
      blocked_d    = '0;
      cat_row_d    = CAT_R0;
      cat_col_d    = CAT_C0;
      cur_row_d    = 3'd0;
      cur_col_d    = 3'd0;
      move_count_d = 7'd0;
`ifdef CATTRAP_PREBLOCK_EN
      pb_cnt_d     = 8'd0;
      pb_cyc_d     = 8'd0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_START;
      blocked_q    <= '0;
      cat_row_q    <= CAT_R0;
      cat_col_q    <= CAT_C0;
      cur_row_q    <= 3'd0;
      cur_col_q    <= 3'd0;
      move_count_q <= 7'd0;
      lfsr_q       <= LFSR_SEED;
      btn_prev_q   <= 5'd0;
      btn_evt_q    <= 5'd0;
      k_q          <= 2'd0;
      best_vld_q   <= 1'b0;
      best_row_q   <= 3'd0;
      best_col_q   <= 3'd0;
      best_dist_q  <= 3'd0;
`ifdef CATTRAP_PREBLOCK_EN
      pb_cnt_q     <= 8'd0;
      pb_cyc_q     <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      blocked_q    <= blocked_d;
      cat_row_q    <= cat_row_d;
      cat_col_q    <= cat_col_d;
      cur_row_q    <= cur_row_d;
      cur_col_q    <= cur_col_d;
      move_count_q <= move_count_d;
      // Fibonacci LFSR, taps 16,15,13,4; free-running in every state.
      lfsr_q       <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]};
      btn_prev_q   <= btn_lvl;
      btn_evt_q    <= btn_lvl & ~btn_prev_q;
      k_q          <= k_d;
      best_vld_q   <= best_vld_d;
      best_row_q   <= best_row_d;
      best_col_q   <= best_col_d;
      best_dist_q  <= best_dist_d;
`ifdef CATTRAP_PREBLOCK_EN
      pb_cnt_q     <= pb_cnt_d;
      pb_cyc_q     <= pb_cyc_d;
`endif
    end
  end

  always_comb begin
    case (state_q)
      S_START: game_state = 2'd0;
      S_LOSE:  game_state = 2'd2;
      S_WIN:   game_state = 2'd3;
      default: game_state = 2'd1;
    endcase
  end

  assign rd_cell    = ({rd_row, rd_col} == cat_idx) ? 2'd2 : {1'b0, blocked_q[{rd_row, rd_col}]};
  assign rd_cursor  = ({rd_row, rd_col} == cur_idx);
  assign cat_row    = cat_row_q;
  assign cat_col    = cat_col_q;
  assign cur_row    = cur_row_q;
  assign cur_col    = cur_col_q;
  assign move_count = move_count_q;

endmodule

// File: tb/tb_cattrap_game_ctrl.sv
// tb_cattrap_game_ctrl: directed bench for cattrap_game_ctrl in its default build.
// Drives button levels one edge at a time and checks the board, cursor, cat and state.
module tb_cattrap_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       BtnC, BtnU, BtnD, BtnL, BtnR;
  logic [2:0] rd_row, rd_col;
  logic [1:0] rd_cell;
  logic       rd_cursor;
  logic [1:0] game_state;
  logic [2:0] cat_row, cat_col, cur_row, cur_col;
  logic [6:0] move_count;

  int total = 0;
  int bad   = 0;

  localparam logic [4:0] B_C = 5'b10000;
  localparam logic [4:0] B_U = 5'b01000;
  localparam logic [4:0] B_D = 5'b00100;
  localparam logic [4:0] B_L = 5'b00010;
  localparam logic [4:0] B_R = 5'b00001;

  always #5 clk = ~clk;

  cattrap_game_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .BtnC       (BtnC),
    .BtnU       (BtnU),
    .BtnD       (BtnD),
    .BtnL       (BtnL),
    .BtnR       (BtnR),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_cell    (rd_cell),
    .rd_cursor  (rd_cursor),
    .game_state (game_state),
    .cat_row    (cat_row),
    .cat_col    (cat_col),
    .cur_row    (cur_row),
    .cur_col    (cur_col),
    .move_count (move_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_btn(input logic [4:0] b);
    {BtnC, BtnU, BtnD, BtnL, BtnR} = b;
  endtask

  // Level high for one edge, low for the next: the event acts on the second edge.
  task automatic press(input logic [4:0] b);
    set_btn(b);
    tick();
    set_btn(5'b0);
    tick();
  endtask

  task automatic query(input int r, input int c);
    rd_row = 3'(r);
    rd_col = 3'(c);
    #1;
  endtask

  task automatic goto(input int r, input int c);
    repeat (7) press(B_U);
    repeat (7) press(B_L);
    repeat (r) press(B_D);
    repeat (c) press(B_R);
  endtask

  // Move cursor, confirm, and wait until the cat result is final (edge N+7).
  task automatic place(input int r, input int c);
    goto(r, c);
    press(B_C);
    repeat (6) tick();
  endtask

  task automatic check_cat(input string tag, input int r, input int c);
    check({tag, "_cat_row"}, 16'(cat_row), 16'(r));
    check({tag, "_cat_col"}, 16'(cat_col), 16'(c));
  endtask

  task automatic check_cur(input string tag, input int r, input int c);
    check({tag, "_cur_row"}, 16'(cur_row), 16'(r));
    check({tag, "_cur_col"}, 16'(cur_col), 16'(c));
  endtask

  // Empty board with the cat at its start cell (3,3).
  task automatic scan_empty(input string tag);
    int errs;
    errs = 0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        query(r, c);
        if (rd_cell !== ((r == 3 && c == 3) ? 2'd2 : 2'd0)) errs++;
      end
    end
    check({tag, "_bad_cells"}, 16'(errs), 16'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    set_btn(5'b0);
    rd_row = 3'd0;
    rd_col = 3'd0;
    tick();
    tick();

    // Reset state
    check("rst_state", 16'(game_state), 16'd0);
    check_cat("rst", 3, 3);
    check_cur("rst", 0, 0);
    check("rst_moves", 16'(move_count), 16'd0);
    query(3, 3);
    check("rst_rd_cat", 16'(rd_cell), 16'd2);
    rst_n = 1'b1;
    tick();

    // START -> PLAY
    press(B_C);
    check("start_play", 16'(game_state), 16'd1);
    scan_empty("play_empty");
    query(0, 0);
    check("cursor_hit", 16'(rd_cursor), 16'd1);
    query(0, 1);
    check("cursor_miss", 16'(rd_cursor), 16'd0);

    // Held buttons: saturation at 0, and one event per hold
    set_btn(B_U);
    repeat (10) tick();
    set_btn(5'b0);
    tick();
    check_cur("hold_u", 0, 0);
    set_btn(B_D);
    repeat (10) tick();
    set_btn(5'b0);
    tick();
    check_cur("hold_d", 1, 0);
    press(B_D);
    press(B_D);
    press(B_R);
    press(B_R);
    check_cur("d3r2", 3, 2);

    // Up and Right together: Up wins, one step only
    press(B_U | B_R);
    check_cur("u_over_r", 2, 2);
    press(B_D);
    press(B_R);
    check_cur("at_cat", 3, 3);

    // Confirm on the cat cell with a direction: both ignored
    press(B_C | B_D);
    repeat (8) tick();
    check_cur("ign_cur", 3, 3);
    check("ign_state", 16'(game_state), 16'd1);
    check("ign_moves", 16'(move_count), 16'd0);
    check_cat("ign", 3, 3);
    query(3, 3);
    check("ign_rd_cat", 16'(rd_cell), 16'd2);
    query(4, 3);
    check("ign_rd_free", 16'(rd_cell), 16'd0);
    press(B_U);
    press(B_U);
    check_cur("still_play", 1, 3);

    // Placement at (1,3) with exact latency; Up/Left tie at distance 2, Up taken
    set_btn(B_C);
    tick();                       // edge N
    set_btn(5'b0);
    tick();                       // N+1
    query(1, 3);
    check("n1_not_yet", 16'(rd_cell), 16'd0);
    tick();                       // N+2
    query(1, 3);
    check("n2_blocked", 16'(rd_cell), 16'd1);
    check("n2_moves", 16'(move_count), 16'd1);
    repeat (4) tick();            // N+6
    check_cat("n6", 3, 3);
    tick();                       // N+7
    check_cat("n7", 2, 3);
    check("n7_state", 16'(game_state), 16'd1);

    // Drive this game to LOSE: (2,3)->(2,2)->(1,2)->(0,2)
    place(7, 7);
    check_cat("lose1", 2, 2);
    place(7, 6);
    check_cat("lose2", 1, 2);
    check("lose2_state", 16'(game_state), 16'd1);
    place(7, 5);
    check_cat("lose3", 0, 2);
    check("lose_state", 16'(game_state), 16'd2);
    check("lose_moves", 16'(move_count), 16'd4);
    press(B_U);
    check_cur("lose_frozen", 7, 5);
    query(1, 3);
    check("lose_rd_blk", 16'(rd_cell), 16'd1);
    query(0, 2);
    check("lose_rd_cat", 16'(rd_cell), 16'd2);
    press(B_C);
    check("lose_restart", 16'(game_state), 16'd0);
    check("restart_moves", 16'(move_count), 16'd0);
    check_cur("restart", 0, 0);
    scan_empty("restart_board");

    // New game to WIN: cat walks into the dead end at (1,3), then (2,3) is sealed
    press(B_C);
    check("win_play", 16'(game_state), 16'd1);
    place(0, 3);
    check_cat("win1", 2, 3);
    place(1, 2);
    check_cat("win2", 1, 3);
    place(1, 4);
    check_cat("win3", 2, 3);
    place(7, 7);
    check_cat("win4", 1, 3);
    check("win4_state", 16'(game_state), 16'd1);
    place(2, 3);
    check("win_state", 16'(game_state), 16'd3);
    check_cat("win5", 1, 3);
    check("win_moves", 16'(move_count), 16'd5);
    press(B_C);
    check("win_restart", 16'(game_state), 16'd0);
    scan_empty("win_clear");

    // Reset during CAT_EVAL
    press(B_C);
    goto(5, 5);
    set_btn(B_C);
    tick();                       // edge N
    set_btn(5'b0);
    tick();                       // N+1, PLACE
    tick();                       // N+2, CAT_EVAL
    check("pre_rst_moves", 16'(move_count), 16'd1);
    rst_n = 1'b0;
    tick();                       // N+3 with reset
    check("mid_rst_state", 16'(game_state), 16'd0);
    check_cat("mid_rst", 3, 3);
    check_cur("mid_rst", 0, 0);
    check("mid_rst_moves", 16'(move_count), 16'd0);
    query(5, 5);
    check("mid_rst_cell", 16'(rd_cell), 16'd0);
    rst_n = 1'b1;
    repeat (6) tick();
    check("post_rst_state", 16'(game_state), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
